// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: picks the oldest redirect pulse by issue age and holds it in a
// single pending slot until fetch accepts it; younger redirects are dropped and counted.
module pc_redirect_arb #(
  parameter int NUM_SRC   = 4,
  parameter int ID_WIDTH  = 8,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*PC_WIDTH-1:0]  src_pc,
  input  logic [NUM_SRC*ID_WIDTH-1:0]  src_issue_id,
  input  logic [ID_WIDTH-1:0]          head_issue_id,
  output logic                         fetch_valid,
  output logic [PC_WIDTH-1:0]          fetch_pc,
  output logic [ID_WIDTH-1:0]          fetch_issue_id,
  input  logic                         fetch_ready,
  output logic [CNT_WIDTH-1:0]         cnt_taken,
  output logic [CNT_WIDTH-1:0]         cnt_dropped
);

  localparam int CW = $clog2(NUM_SRC + 1) + 1;
  localparam int SW = CNT_WIDTH + CW;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                state_r, state_n;
  logic [PC_WIDTH-1:0]   slot_pc_r, slot_pc_n;
  logic [ID_WIDTH-1:0]   slot_id_r, slot_id_n;
  logic [CNT_WIDTH-1:0]  cnt_taken_r, cnt_taken_n;
  logic [CNT_WIDTH-1:0]  cnt_dropped_r, cnt_dropped_n;

  logic                  win_valid_s;
  logic [PC_WIDTH-1:0]   win_pc_s;
  logic [ID_WIDTH-1:0]   win_id_s;
  logic [ID_WIDTH-1:0]   win_age_s;
  logic [ID_WIDTH-1:0]   cand_age_s;
  logic [CW-1:0]         nvalid_s;
  logic [CW-1:0]         drop_inc_s;
  logic [SW-1:0]         drop_sum_s;
  logic [SW-1:0]         take_sum_s;
  logic                  accept_s;

  // Age relative to the oldest in-flight instruction; modular subtraction handles id wrap.
  function automatic logic [ID_WIDTH-1:0] age_f(input logic [ID_WIDTH-1:0] id,
                                                input logic [ID_WIDTH-1:0] head);
    return id - head;
  endfunction

  assign accept_s = (state_r == PEND) && fetch_ready;

  // Oldest-valid-source selection; strict compare keeps the lowest index on ties.
  always_comb begin
    win_valid_s = 1'b0;
    win_pc_s    = {PC_WIDTH{1'b0}};
    win_id_s    = {ID_WIDTH{1'b0}};
    win_age_s   = {ID_WIDTH{1'b0}};
    cand_age_s  = {ID_WIDTH{1'b0}};
    nvalid_s    = {CW{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_age_s = age_f(src_issue_id[i*ID_WIDTH +: ID_WIDTH], head_issue_id);
      if (src_valid[i]) begin
        nvalid_s = nvalid_s + CW'(1);
        if (!win_valid_s || (cand_age_s < win_age_s)) begin
          win_valid_s = 1'b1;
          win_pc_s    = src_pc[i*PC_WIDTH +: PC_WIDTH];
          win_id_s    = src_issue_id[i*ID_WIDTH +: ID_WIDTH];
          win_age_s   = cand_age_s;
        end else begin
          win_valid_s = win_valid_s;
        end
      end else begin
        nvalid_s = nvalid_s;
      end
    end
  end

  // Slot next-state: load, replace by an older winner, hold, or release on accept.
  always_comb begin
    state_n   = state_r;
    slot_pc_n = slot_pc_r;
    slot_id_n = slot_id_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_n   = PEND;
          slot_pc_n = win_pc_s;
          slot_id_n = win_id_s;
        end else begin
          state_n = IDLE;
        end
      end
      PEND: begin
        if (win_valid_s) begin
          // After an accept the consumed slot is gone, so the winner loads unconditionally.
          if (accept_s || (win_age_s < age_f(slot_id_r, head_issue_id))) begin
            slot_pc_n = win_pc_s;
            slot_id_n = win_id_s;
          end else begin
            slot_pc_n = slot_pc_r;
          end
        end else if (accept_s) begin
          state_n = IDLE;
        end else begin
          state_n = PEND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Counter increments summed per cycle, then saturated at all-ones.
  always_comb begin
    drop_inc_s = {CW{1'b0}};
    if (win_valid_s) begin
      drop_inc_s = nvalid_s - CW'(1);
      if ((state_r == PEND) && !accept_s) begin
        drop_inc_s = drop_inc_s + CW'(1);
      end else begin
        drop_inc_s = drop_inc_s;
      end
    end else begin
      drop_inc_s = {CW{1'b0}};
    end
    drop_sum_s    = SW'(cnt_dropped_r) + SW'(drop_inc_s);
    take_sum_s    = SW'(cnt_taken_r) + SW'(accept_s);
    cnt_dropped_n = (drop_sum_s > CNT_MAX) ? {CNT_WIDTH{1'b1}} : drop_sum_s[CNT_WIDTH-1:0];
    cnt_taken_n   = (take_sum_s > CNT_MAX) ? {CNT_WIDTH{1'b1}} : take_sum_s[CNT_WIDTH-1:0];
  end

  // State, slot and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      slot_pc_r     <= {PC_WIDTH{1'b0}};
      slot_id_r     <= {ID_WIDTH{1'b0}};
      cnt_taken_r   <= {CNT_WIDTH{1'b0}};
      cnt_dropped_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r       <= state_n;
      slot_pc_r     <= slot_pc_n;
      slot_id_r     <= slot_id_n;
      cnt_taken_r   <= cnt_taken_n;
      cnt_dropped_r <= cnt_dropped_n;
    end
  end

  assign fetch_valid    = (state_r == PEND);
  assign fetch_pc       = slot_pc_r;
  assign fetch_issue_id = slot_id_r;
  assign cnt_taken      = cnt_taken_r;
  assign cnt_dropped    = cnt_dropped_r;

endmodule

// File: tb/tb_pc_redirect_arb.sv
// Self-checking bench for pc_redirect_arb: directed scenarios plus randomized traffic
// checked against a transaction-level model of the pending slot and counters.
module tb_pc_redirect_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   src_valid = 4'd0;
  logic [127:0] src_pc = 128'd0;
  logic [31:0]  src_issue_id = 32'd0;
  logic [7:0]   head_issue_id = 8'd0;
  logic         fetch_valid;
  logic [31:0]  fetch_pc;
  logic [7:0]   fetch_issue_id;
  logic         fetch_ready = 1'b0;
  logic [15:0]  cnt_taken;
  logic [15:0]  cnt_dropped;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_valid;
  logic [31:0] m_pc;
  logic [7:0]  m_id;
  int          m_taken;
  int          m_dropped;

  pc_redirect_arb dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_pc(src_pc),
    .src_issue_id(src_issue_id), .head_issue_id(head_issue_id),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_issue_id(fetch_issue_id),
    .fetch_ready(fetch_ready), .cnt_taken(cnt_taken), .cnt_dropped(cnt_dropped)
  );

  always #5 clk = ~clk;

  task automatic set_src(input int i, input logic [7:0] id, input logic [31:0] pc);
    src_valid[i] = 1'b1;
    src_issue_id[i*8 +: 8] = id;
    src_pc[i*32 +: 32] = pc;
  endtask

  // One clock of the reference: oldest request wins, everything else that loses is a drop.
  task automatic model_step();
    int n = 0;
    int best = -1;
    logic [7:0] a, bage, page;
    bit acc;
    acc = m_valid && fetch_ready;
    bage = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (src_valid[i]) begin
        n++;
        a = src_issue_id[i*8 +: 8] - head_issue_id;
        if (best < 0 || a < bage) begin best = i; bage = a; end
      end
    end
    if (acc) m_taken = (m_taken + 1 > 65535) ? 65535 : m_taken + 1;
    if (n > 0) begin
      m_dropped += n - 1;
      if (!m_valid || acc) begin
        m_valid = 1; m_pc = src_pc[best*32 +: 32]; m_id = src_issue_id[best*8 +: 8];
      end else begin
        m_dropped += 1;
        page = m_id - head_issue_id;
        if (bage < page) begin m_pc = src_pc[best*32 +: 32]; m_id = src_issue_id[best*8 +: 8]; end
      end
      if (m_dropped > 65535) m_dropped = 65535;
    end else if (acc) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    src_valid = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = 4'd0; fetch_ready = 1'b0; head_issue_id = 8'd0;
    m_valid = 0; m_pc = 32'd0; m_id = 8'd0; m_taken = 0; m_dropped = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) cycle();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
    checks++; if (fetch_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", fetch_pc); end
    checks++; if (cnt_taken !== 16'd0) begin errors++; $display("FAIL reset_taken got %0d exp 0", cnt_taken); end
    checks++; if (cnt_dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped got %0d exp 0", cnt_dropped); end
  endtask

  task automatic test_single();
    do_reset();
    set_src(1, 8'h05, 32'h400);
    cycle();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h400 || fetch_issue_id !== 8'h05) begin
      errors++; $display("FAIL single_load got v=%b pc=%h id=%h exp v=1 pc=400 id=05", fetch_valid, fetch_pc, fetch_issue_id); end
    repeat (3) cycle();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h400) begin
      errors++; $display("FAIL single_hold got v=%b pc=%h exp v=1 pc=400", fetch_valid, fetch_pc); end
    fetch_ready = 1'b1;
    cycle();
    fetch_ready = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || cnt_taken !== 16'd1) begin
      errors++; $display("FAIL single_accept got v=%b taken=%0d exp v=0 taken=1", fetch_valid, cnt_taken); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_src(0, 8'h09, 32'h100);
    set_src(2, 8'h03, 32'h300);
    cycle();
    checks++; if (fetch_pc !== 32'h300 || cnt_dropped !== 16'd1) begin
      errors++; $display("FAIL same_cycle got pc=%h dropped=%0d exp pc=300 dropped=1", fetch_pc, cnt_dropped); end
  endtask

  task automatic test_override();
    do_reset();
    set_src(0, 8'h07, 32'h700);
    cycle();
    set_src(3, 8'h02, 32'h222);
    cycle();
    checks++; if (fetch_pc !== 32'h222 || fetch_issue_id !== 8'h02 || cnt_dropped !== 16'd1) begin
      errors++; $display("FAIL override_replace got pc=%h id=%h dropped=%0d exp pc=222 id=02 dropped=1", fetch_pc, fetch_issue_id, cnt_dropped); end
    set_src(0, 8'h08, 32'h888);
    cycle();
    checks++; if (fetch_pc !== 32'h222 || cnt_dropped !== 16'd2) begin
      errors++; $display("FAIL override_keep got pc=%h dropped=%0d exp pc=222 dropped=2", fetch_pc, cnt_dropped); end
  endtask

  task automatic test_wrap();
    do_reset();
    head_issue_id = 8'hFE;
    set_src(1, 8'h01, 32'h111);
    cycle();
    set_src(0, 8'hFF, 32'hFFF);
    cycle();
    checks++; if (fetch_pc !== 32'hFFF || fetch_issue_id !== 8'hFF || cnt_dropped !== 16'd1) begin
      errors++; $display("FAIL wrap got pc=%h id=%h dropped=%0d exp pc=fff id=ff dropped=1", fetch_pc, fetch_issue_id, cnt_dropped); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_src(0, 8'h04, 32'h44);
    cycle();
    fetch_ready = 1'b1;
    set_src(2, 8'h09, 32'h99);
    cycle();
    fetch_ready = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h99 || cnt_taken !== 16'd1 || cnt_dropped !== 16'd0) begin
      errors++; $display("FAIL back_to_back got v=%b pc=%h taken=%0d dropped=%0d exp v=1 pc=99 taken=1 dropped=0",
                         fetch_valid, fetch_pc, cnt_taken, cnt_dropped); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_src(3, 8'h10, 32'h1234);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'd0 || cnt_dropped !== 16'd0) begin
      errors++; $display("FAIL async_reset got v=%b pc=%h dropped=%0d exp v=0 pc=0 dropped=0", fetch_valid, fetch_pc, cnt_dropped); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      src_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      src_pc = {$urandom, $urandom, $urandom, $urandom};
      src_issue_id = $urandom;
      if ($urandom_range(0, 7) == 0) head_issue_id = 8'($urandom_range(0, 255));
      fetch_ready = ($urandom_range(0, 2) == 0);
      model_step();
      @(posedge clk);
      #1;
      checks++; if (fetch_valid !== m_valid) begin errors++; $display("FAIL rand_valid c=%0d got %b exp %b", c, fetch_valid, m_valid); end
      if (m_valid) begin
        checks++; if (fetch_pc !== m_pc || fetch_issue_id !== m_id) begin
          errors++; $display("FAIL rand_slot c=%0d got pc=%h id=%h exp pc=%h id=%h", c, fetch_pc, fetch_issue_id, m_pc, m_id); end
      end
      checks++; if (cnt_taken !== 16'(m_taken) || cnt_dropped !== 16'(m_dropped)) begin
        errors++; $display("FAIL rand_cnt c=%0d got taken=%0d dropped=%0d exp taken=%0d dropped=%0d", c, cnt_taken, cnt_dropped, m_taken, m_dropped); end
    end
    fetch_ready = 1'b0;
    src_valid = 4'd0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_override();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
